// File: rtl/operator_slot_sequencer.sv
// operator_slot_sequencer: time-slot scheduler for the shared operator datapath.
// Each frame walks bank 0 ops 0..N-1, then bank 1 ops 0..N-1, one slot per
// handshake. It then waits out the pipeline latency and pulses frame_done.
// Optional feature macro: OPL3_SLOT_SKIP_EN. When it is defined, slots whose
// bit is clear in the mask latched at frame start are skipped.
module operator_slot_sequencer #(
    parameter int NUM_BANKS              = 2,
    parameter int NUM_OPERATORS_PER_BANK = 18,
    parameter int PIPELINE_DEPTH         = 6,
    parameter int OVERRUN_CNT_WIDTH      = 8
) (
    input  logic                                        clk,
    input  logic                                        reset_n,
    input  logic                                        sample_clk_en,
    input  logic [NUM_BANKS*NUM_OPERATORS_PER_BANK-1:0] slot_en_mask,
    input  logic                                        slot_ready,
    output logic                                        slot_valid,
    output logic [$clog2(NUM_BANKS)-1:0]                bank_num,
    output logic [$clog2(NUM_OPERATORS_PER_BANK)-1:0]   op_num,
    output logic                                        slot_last,
    output logic                                        busy,
    output logic                                        frame_done,
    output logic                                        overrun,
    output logic [OVERRUN_CNT_WIDTH-1:0]                overrun_cnt
);
    localparam int NUM_SLOTS = NUM_BANKS * NUM_OPERATORS_PER_BANK;
    localparam int BANK_W    = $clog2(NUM_BANKS);
    localparam int OP_W      = $clog2(NUM_OPERATORS_PER_BANK);
    localparam int DRAIN_W   = (PIPELINE_DEPTH > 1) ? $clog2(PIPELINE_DEPTH) : 1;
    localparam logic [DRAIN_W-1:0]           DRAIN_LOAD = DRAIN_W'(PIPELINE_DEPTH - 1);
    localparam logic [DRAIN_W-1:0]           DRAIN_ONE  = DRAIN_W'(1);
    localparam logic [OVERRUN_CNT_WIDTH-1:0] CNT_ONE    = OVERRUN_CNT_WIDTH'(1);
    localparam logic [OVERRUN_CNT_WIDTH-1:0] CNT_MAX    = {OVERRUN_CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                         state_q, state_d;
    logic                           slot_valid_q, slot_valid_d;
    logic [BANK_W-1:0]              bank_q, bank_d;
    logic [OP_W-1:0]                op_q, op_d;
    logic                           slot_last_q, slot_last_d;
    logic                           busy_q, busy_d;
    logic                           frame_done_q, frame_done_d;
    logic [DRAIN_W-1:0]             drain_q, drain_d;
    logic                           overrun_q, overrun_d;
    logic [OVERRUN_CNT_WIDTH-1:0]   overrun_cnt_q, overrun_cnt_d;

    logic                           start_s;
    logic                           advance_s;
    logic                           overrun_evt_s;
    logic                           first_any_s;
    logic [BANK_W-1:0]              first_bank_s, next_bank_s;
    logic [OP_W-1:0]                first_op_s, next_op_s;
    logic                           first_last_s, next_last_s;

    // A pulse on the frame_done cycle counts as an overrun, so only a truly idle cycle may start a frame.
    always_comb begin
        start_s       = sample_clk_en && (state_q == ST_IDLE) && !frame_done_q;
        advance_s     = (state_q == ST_RUN) && slot_ready && !slot_last_q;
        overrun_evt_s = sample_clk_en && ((state_q != ST_IDLE) || frame_done_q);
    end

`ifdef OPL3_SLOT_SKIP_EN
    localparam int IDX_W = $clog2(NUM_SLOTS);

    logic [NUM_SLOTS-1:0] mask_q, mask_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     hi_q, hi_d;
    logic [IDX_W-1:0]     first_idx_s, next_idx_s, hi_s;

    // Lowest set bit at or above 'from'. It returns 0 when no such bit exists.
    function automatic logic [IDX_W-1:0] lowest_from(input logic [NUM_SLOTS-1:0] m, input int from);
        logic [IDX_W-1:0] r;
        r = {IDX_W{1'b0}};
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (m[i] && (i >= from)) r = IDX_W'(i);
            else                     r = r;
        end
        return r;
    endfunction

    // Highest set bit. It returns 0 for an all-zero mask.
    function automatic logic [IDX_W-1:0] highest_set(input logic [NUM_SLOTS-1:0] m);
        logic [IDX_W-1:0] r;
        r = {IDX_W{1'b0}};
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (m[i]) r = IDX_W'(i);
            else      r = r;
        end
        return r;
    endfunction

    function automatic logic [BANK_W-1:0] idx_bank(input logic [IDX_W-1:0] idx);
        logic [BANK_W-1:0] r;
        r = {BANK_W{1'b0}};
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (int'(idx) >= b * NUM_OPERATORS_PER_BANK) r = BANK_W'(b);
            else                                         r = r;
        end
        return r;
    endfunction

    function automatic logic [OP_W-1:0] idx_op(input logic [IDX_W-1:0] idx);
        return OP_W'(int'(idx) - int'(idx_bank(idx)) * NUM_OPERATORS_PER_BANK);
    endfunction

    // Priority search: find the first slot from the live mask and the next enabled slot from the latched mask.
    always_comb begin
        first_any_s  = |slot_en_mask;
        first_idx_s  = lowest_from(slot_en_mask, 0);
        hi_s         = highest_set(slot_en_mask);
        first_bank_s = idx_bank(first_idx_s);
        first_op_s   = idx_op(first_idx_s);
        first_last_s = (first_idx_s == hi_s);
        next_idx_s   = lowest_from(mask_q, int'(idx_q) + 1);
        next_bank_s  = idx_bank(next_idx_s);
        next_op_s    = idx_op(next_idx_s);
        next_last_s  = (next_idx_s == hi_q);
    end

    // Latch the mask and its highest enabled slot at frame start, and track the current linear index.
    always_comb begin
        mask_d = mask_q;
        idx_d  = idx_q;
        hi_d   = hi_q;
        if (start_s) begin
            mask_d = slot_en_mask;
            idx_d  = first_idx_s;
            hi_d   = hi_s;
        end else if (advance_s) begin
            idx_d  = next_idx_s;
        end else begin
            idx_d  = idx_q;
        end
    end

    // Frame mask and slot index registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mask_q <= {NUM_SLOTS{1'b0}};
            idx_q  <= {IDX_W{1'b0}};
            hi_q   <= {IDX_W{1'b0}};
        end else begin
            mask_q <= mask_d;
            idx_q  <= idx_d;
            hi_q   <= hi_d;
        end
    end
`else
    logic unused_mask_s;
    assign unused_mask_s = ^slot_en_mask;

    // Plain walk: the op counter wraps into the next bank, and every slot is presented.
    always_comb begin
        first_any_s  = 1'b1;
        first_bank_s = {BANK_W{1'b0}};
        first_op_s   = {OP_W{1'b0}};
        first_last_s = (NUM_SLOTS == 1);
        if (op_q == OP_W'(NUM_OPERATORS_PER_BANK - 1)) begin
            next_op_s   = {OP_W{1'b0}};
            next_bank_s = bank_q + BANK_W'(1);
        end else begin
            next_op_s   = op_q + OP_W'(1);
            next_bank_s = bank_q;
        end
        next_last_s = (next_bank_s == BANK_W'(NUM_BANKS - 1)) &&
                      (next_op_s == OP_W'(NUM_OPERATORS_PER_BANK - 1));
    end
`endif

    // Frame FSM: slot presentation, drain countdown and the frame_done pulse.
    always_comb begin
        state_d      = state_q;
        slot_valid_d = slot_valid_q;
        bank_d       = bank_q;
        op_d         = op_q;
        slot_last_d  = slot_last_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        drain_d      = drain_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s && first_any_s) begin
                    state_d      = ST_RUN;
                    slot_valid_d = 1'b1;
                    bank_d       = first_bank_s;
                    op_d         = first_op_s;
                    slot_last_d  = first_last_s;
                    busy_d       = 1'b1;
                end else if (start_s && (PIPELINE_DEPTH == 1)) begin
                    frame_done_d = 1'b1;
                end else if (start_s) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_LOAD;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (slot_ready && slot_last_q) begin
                    slot_valid_d = 1'b0;
                    slot_last_d  = 1'b0;
                    if (PIPELINE_DEPTH == 1) begin
                        state_d      = ST_IDLE;
                        busy_d       = 1'b0;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                        drain_d = DRAIN_LOAD;
                    end
                end else if (slot_ready) begin
                    bank_d      = next_bank_s;
                    op_d        = next_op_s;
                    slot_last_d = next_last_s;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (drain_q <= DRAIN_ONE) begin
                    state_d      = ST_IDLE;
                    busy_d       = 1'b0;
                    frame_done_d = 1'b1;
                end else begin
                    drain_d = drain_q - DRAIN_ONE;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                slot_valid_d = 1'b0;
                slot_last_d  = 1'b0;
                busy_d       = 1'b0;
            end
        endcase
    end

    // Sticky overrun flag and saturating overrun counter.
    always_comb begin
        overrun_d     = overrun_q;
        overrun_cnt_d = overrun_cnt_q;
        if (overrun_evt_s && (overrun_cnt_q != CNT_MAX)) begin
            overrun_d     = 1'b1;
            overrun_cnt_d = overrun_cnt_q + CNT_ONE;
        end else if (overrun_evt_s) begin
            overrun_d     = 1'b1;
        end else begin
            overrun_d     = overrun_q;
        end
    end

    // State and output registers. The synchronous reset clears every output.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            slot_valid_q  <= 1'b0;
            bank_q        <= {BANK_W{1'b0}};
            op_q          <= {OP_W{1'b0}};
            slot_last_q   <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            drain_q       <= {DRAIN_W{1'b0}};
            overrun_q     <= 1'b0;
            overrun_cnt_q <= {OVERRUN_CNT_WIDTH{1'b0}};
        end else begin
            state_q       <= state_d;
            slot_valid_q  <= slot_valid_d;
            bank_q        <= bank_d;
            op_q          <= op_d;
            slot_last_q   <= slot_last_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            drain_q       <= drain_d;
            overrun_q     <= overrun_d;
            overrun_cnt_q <= overrun_cnt_d;
        end
    end

    assign slot_valid  = slot_valid_q;
    assign bank_num    = bank_q;
    assign op_num      = op_q;
    assign slot_last   = slot_last_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign overrun     = overrun_q;
    assign overrun_cnt = overrun_cnt_q;

endmodule

// File: tb/tb_operator_slot_sequencer.sv
// Directed bench for operator_slot_sequencer. It covers full frames, stalls,
// overruns, counter saturation and mid-frame reset. The masked-skip frames
// run only when OPL3_SLOT_SKIP_EN is defined.
module tb_operator_slot_sequencer;
    localparam int PD = 6;
`ifdef OPL3_SLOT_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sample_clk_en;
    logic [35:0] slot_en_mask;
    logic        slot_ready;
    logic        slot_valid;
    logic [0:0]  bank_num;
    logic [4:0]  op_num;
    logic        slot_last;
    logic        busy;
    logic        frame_done;
    logic        overrun;
    logic [7:0]  overrun_cnt;

    int checks = 0;
    int errors = 0;

    operator_slot_sequencer #(
        .NUM_BANKS(2), .NUM_OPERATORS_PER_BANK(18),
        .PIPELINE_DEPTH(PD), .OVERRUN_CNT_WIDTH(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sample_clk_en(sample_clk_en),
        .slot_en_mask(slot_en_mask), .slot_ready(slot_ready),
        .slot_valid(slot_valid), .bank_num(bank_num), .op_num(op_num),
        .slot_last(slot_last), .busy(busy), .frame_done(frame_done),
        .overrun(overrun), .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(slot_valid), 32'd0);
        chk({tag, "_bank"}, 32'(bank_num), 32'd0);
        chk({tag, "_op"}, 32'(op_num), 32'd0);
        chk({tag, "_last"}, 32'(slot_last), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_ovr"}, 32'(overrun), 32'd0);
        chk({tag, "_ovrcnt"}, 32'(overrun_cnt), 32'd0);
    endtask

    // One frame: start pulse, the expected slot walk (optionally stalled), the drain and frame_done.
    task automatic run_frame(input logic [35:0] mask, input bit stall, input int extra_at, input bit pulse_on_done);
        int exp_b[$];
        int exp_o[$];
        int k;
        int c;
        int stalls;
        for (int b = 0; b < 2; b++) begin
            for (int o = 0; o < 18; o++) begin
                if (mask[b*18+o] || !SKIP) begin
                    exp_b.push_back(b);
                    exp_o.push_back(o);
                end
            end
        end
        slot_en_mask  = mask;
        slot_ready    = 1'b1;
        sample_clk_en = 1'b1;
        tick();
        sample_clk_en = 1'b0;
        c = 1;
        k = 0;
        stalls = 0;
        while (k < exp_b.size()) begin
            chk("run_valid", 32'(slot_valid), 32'd1);
            chk("run_bank", 32'(bank_num), 32'(exp_b[k]));
            chk("run_op", 32'(op_num), 32'(exp_o[k]));
            chk("run_last", 32'(slot_last), 32'(k == exp_b.size() - 1));
            chk("run_busy", 32'(busy), 32'd1);
            chk("run_done", 32'(frame_done), 32'd0);
            if (stall && (stalls < 4) && ($urandom_range(0, 1) == 0)) begin
                slot_ready = 1'b0;
                stalls++;
            end else begin
                slot_ready = 1'b1;
                stalls = 0;
                k++;
            end
            slot_en_mask  = 36'({$urandom(), $urandom()});
            sample_clk_en = (c == extra_at);
            tick();
            sample_clk_en = 1'b0;
            c++;
        end
        slot_ready = 1'b1;
        for (int d = 0; d < PD - 1; d++) begin
            chk("drain_valid", 32'(slot_valid), 32'd0);
            chk("drain_busy", 32'(busy), 32'd1);
            chk("drain_done", 32'(frame_done), 32'd0);
            tick();
        end
        chk("done_pulse", 32'(frame_done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_valid", 32'(slot_valid), 32'd0);
        sample_clk_en = pulse_on_done;
        tick();
        sample_clk_en = 1'b0;
        chk("done_single", 32'(frame_done), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_valid", 32'(slot_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n       = 1'b0;
        sample_clk_en = 1'b0;
        slot_en_mask  = 36'h0;
        slot_ready    = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        reset_n = 1'b1;
        tick();

        // Full unstalled frame, then a frame with random backpressure.
        run_frame(36'hF_FFFF_FFFF, 1'b0, -1, 1'b0);
        chk("clean_ovr", 32'(overrun), 32'd0);
        run_frame(36'hF_FFFF_FFFF, 1'b1, -1, 1'b0);
        chk("stall_ovr", 32'(overrun), 32'd0);

        // Overrun at t+20 and again on the frame_done cycle.
        run_frame(36'hF_FFFF_FFFF, 1'b0, 20, 1'b1);
        chk("ovr_flag", 32'(overrun), 32'd1);
        chk("ovr_cnt2", 32'(overrun_cnt), 32'd2);
        run_frame(36'hF_FFFF_FFFF, 1'b0, -1, 1'b0);
        chk("ovr_cnt_hold", 32'(overrun_cnt), 32'd2);

        // Saturation: the frame is held stalled on slot (0,0) while pulses pile up.
        slot_ready    = 1'b0;
        sample_clk_en = 1'b1;
        tick();
        for (int i = 0; i < 250; i++) tick();
        chk("sat_cnt252", 32'(overrun_cnt), 32'd252);
        for (int i = 0; i < 50; i++) tick();
        sample_clk_en = 1'b0;
        chk("sat_cnt255", 32'(overrun_cnt), 32'd255);
        chk("sat_valid_held", 32'(slot_valid), 32'd1);
        chk("sat_op_held", 32'(op_num), 32'd0);

        // Reset while slot (0,9) is presented.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        slot_ready    = 1'b1;
        sample_clk_en = 1'b1;
        tick();
        sample_clk_en = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("pre_rst_op9", 32'(op_num), 32'd9);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk_all_zero("midrst");
        for (int i = 0; i < 12; i++) begin
            chk("midrst_nodone", 32'(frame_done), 32'd0);
            tick();
        end
        run_frame(36'hF_FFFF_FFFF, 1'b0, -1, 1'b0);

`ifdef OPL3_SLOT_SKIP_EN
        run_frame(36'h0_0000_0005, 1'b0, -1, 1'b0);
        run_frame(36'h0_0000_0000, 1'b0, -1, 1'b0);
        chk("skip_ovr", 32'(overrun), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/operator_slot_sequencer.md
# operator_slot_sequencer

Time-slot scheduler for the shared operator datapath. On each sample-rate enable it walks the 2 banks × 18 operator slots in order, presenting one slot index per handshake to the operator pipeline. It then waits for the pipeline to drain and signals frame completion to the channel mixer. Sample-enable pulses that arrive while a frame is still in progress are flagged as overruns.

## Interface
Parameters:
- NUM_BANKS, 2, number of register banks
- NUM_OPERATORS_PER_BANK, 18, operator slots per bank
- PIPELINE_DEPTH, 6, cycles from slot acceptance to the operator output being valid; legal range ≥1
- OVERRUN_CNT_WIDTH, 8, width of the saturating overrun counter

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- sample_clk_en  in  1  one-cycle frame start pulse
- slot_en_mask  in  NUM_BANKS*NUM_OPERATORS_PER_BANK  per-slot enable; bit index = bank*18+op
- slot_ready  in  1  operator pipeline accepts a slot
- slot_valid  out  1  slot index is valid
- bank_num  out  $clog2(NUM_BANKS)  bank of the current slot
- op_num  out  $clog2(NUM_OPERATORS_PER_BANK)  operator of the current slot
- slot_last  out  1  current slot is the final slot of the frame
- busy  out  1  frame in progress (RUN or DRAIN)
- frame_done  out  1  one-cycle pulse when the frame is fully drained
- overrun  out  1  sticky flag; cleared only by reset
- overrun_cnt  out  OVERRUN_CNT_WIDTH  saturating count of overrun events

## Operation
States:
- **IDLE**
  - On sample_clk_en, load the first slot and go to RUN.
- **RUN**
  - slot_valid=1.
  - On slot_valid && slot_ready:
    - if slot_last, go to DRAIN and load drain_cnt=PIPELINE_DEPTH-1;
    - otherwise advance to the next slot.
  - While slot_ready=0, the slot is held and all outputs stay stable.
- **DRAIN**
  - slot_valid=0.
  - Decrement drain_cnt each cycle.
  - When drain_cnt==0, pulse frame_done and go to IDLE.

Slot order and indexing:
- Order: op_num 0..17 in bank 0, then op_num 0..17 in bank 1.
- Linear index = bank*18+op.
- Wrap from op 17 to op 0 increments the bank.
- slot_last = the current slot is the highest-indexed emitted slot.

Overrun:
- sample_clk_en while in RUN or DRAIN:
  - sets overrun;
  - increments overrun_cnt, saturating at all-ones;
  - does not restart or extend the current frame, and the pulse is dropped.
- sample_clk_en in the same cycle that frame_done is pulsed is also an overrun.

Reset:
- Reset mid-frame returns to IDLE immediately, with no frame_done.
- All outputs reset to 0: slot_valid, bank_num, op_num, slot_last, busy, frame_done, overrun, overrun_cnt.

Other rules:
- busy = (state != IDLE), registered.
- slot_en_mask is sampled once into a frame register when the frame starts.
- Mask changes mid-frame have no effect on the current frame.

## Timing
- sample_clk_en at cycle t → slot_valid=1 at t+1 with the first slot.
- With slot_ready held at 1, one slot is accepted per cycle:
  - all 36 slots are accepted at t+1..t+36;
  - the last handshake is at t+36;
  - frame_done pulses at t+36+PIPELINE_DEPTH;
  - busy drops in the same cycle as the frame_done pulse.
- Each cycle of slot_ready=0 in RUN delays every later event by one cycle.
- Outputs are registered; slot_valid has no combinational path from slot_ready.
- The next-slot computation (priority search over the mask) and its registers must close timing at CLK_FREQ.

## Configuration
- Macro: OPL3_SLOT_SKIP_EN.
- **Defined:**
  - Slots whose latched mask bit is 0 are skipped and never presented.
  - Skipping adds no cycles; the next enabled slot follows the previous one directly.
  - If the latched mask is all zero, go IDLE → DRAIN directly, so frame_done pulses at t+1+PIPELINE_DEPTH−1, i.e. t+PIPELINE_DEPTH.
  - slot_last marks the highest enabled slot.
- **Undefined:**
  - slot_en_mask is ignored and all 36 slots are always emitted.
  - The mask register and the priority search are not synthesized.

## Test plan
- Reset, then sample_clk_en at t=10 with slot_ready=1 and PIPELINE_DEPTH=6 → 36 consecutive slots at t=11..46 in order (0,0)…(0,17),(1,0)…(1,17); slot_last only at t=46; frame_done single pulse at t=52; busy high for t=11..51.
- Random slot_ready backpressure, 50% duty → slot sequence identical to the unstalled run; outputs stable during every stall; frame_done exactly PIPELINE_DEPTH cycles after the last handshake.
- Second sample_clk_en at t+20 and a third in the same cycle as frame_done → overrun=1, overrun_cnt=2, exactly one frame_done; the next clean pulse starts a normal frame.
- Drive 300 overruns with OVERRUN_CNT_WIDTH=8 → overrun_cnt saturates at 255.
- reset_n=0 for one cycle at slot (0,9) → all outputs 0 the next cycle, no frame_done; a fresh sample_clk_en restarts at (0,0).
- With OPL3_SLOT_SKIP_EN defined:
  - mask=36'h0_0000_0005 → only slots (0,0),(0,2) emitted, slot_last on (0,2), frame_done 6 cycles later;
  - mask=0 → frame_done at t+6, no slot_valid.
